// File: rtl/logit_argmax_classifier.sv
// Argmax over a snapshot of signed logits, scanned one per clock.
// Reports the winning index, the saturated best-minus-second margin and a confidence flag.
module logit_argmax_classifier #(
  parameter int unsigned N_CLASSES  = 3,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned MARGIN_W   = 16,
  parameter int unsigned MARGIN_MIN = 16,
  localparam int unsigned CW = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLASSES*DATA_W-1:0]   logits,
  input  logic                          logits_valid,
  output logic                          busy,
  output logic                          class_valid,
  output logic [CW-1:0]                 class_id,
  output logic [MARGIN_W-1:0]           margin,
  output logic                          confident,
  output logic                          overrun
);

  localparam int unsigned WW = (DATA_W + 1 > MARGIN_W) ? DATA_W + 1 : MARGIN_W;
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [WW-1:0] MMAX = WW'({MARGIN_W{1'b1}});

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                    state_q;
  logic signed [DATA_W-1:0]  snap_q [N_CLASSES];
  logic signed [DATA_W-1:0]  best_q, second_q;
  logic [CW-1:0]             best_idx_q, idx_q;
  logic                      busy_q, class_valid_q, confident_q, overrun_q;
  logic [CW-1:0]             class_id_q;
  logic [MARGIN_W-1:0]       margin_q;

  logic signed [DATA_W-1:0]  logit0, cand;
  logic signed [DATA_W-1:0]  best_d, second_d, fin_best, fin_second;
  logic [CW-1:0]             best_idx_d;
  logic [DATA_W:0]           diff;
  logic [WW-1:0]             diff_w;
  logic [MARGIN_W-1:0]       margin_d;
  logic                      confident_d;

  assign logit0 = logits[DATA_W-1:0];

  // The last compare and the result registration share one edge, so the
  // result strobe lands N_CLASSES cycles after capture with the FSM already idle.
  always_comb begin
    cand       = snap_q[idx_q];
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    if (cand > best_q) begin
      second_d   = best_q;
      best_d     = cand;
      best_idx_d = idx_q;
    end else if (cand > second_q) begin
      second_d = cand;
    end
    if (state_q == IDLE) begin
      fin_best   = logit0;
      fin_second = MIN_VAL;
    end else begin
      fin_best   = best_d;
      fin_second = second_d;
    end
    diff        = {fin_best[DATA_W-1], fin_best} - {fin_second[DATA_W-1], fin_second};
    diff_w      = WW'(diff);
    margin_d    = (diff_w > MMAX) ? '1 : diff_w[MARGIN_W-1:0];
    confident_d = (margin_d >= MARGIN_W'(MARGIN_MIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      best_q        <= '0;
      second_q      <= '0;
      best_idx_q    <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      class_valid_q <= 1'b0;
      class_id_q    <= '0;
      margin_q      <= '0;
      confident_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (logits_valid) begin
            for (int unsigned i = 0; i < N_CLASSES; i++) begin
              snap_q[i] <= logits[i*DATA_W +: DATA_W];
            end
            best_q     <= logit0;
            best_idx_q <= '0;
            second_q   <= MIN_VAL;
            idx_q      <= CW'(1);
            if (N_CLASSES == 1) begin
              class_id_q    <= '0;
              margin_q      <= margin_d;
              confident_q   <= confident_d;
              class_valid_q <= 1'b1;
            end else begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (logits_valid) overrun_q <= 1'b1;
          best_q     <= best_d;
          second_q   <= second_d;
          best_idx_q <= best_idx_d;
          idx_q      <= idx_q + CW'(1);
          if (idx_q == CW'(N_CLASSES - 1)) begin
            class_id_q    <= best_idx_d;
            margin_q      <= margin_d;
            confident_q   <= confident_d;
            class_valid_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign class_valid = class_valid_q;
  assign class_id    = class_id_q;
  assign margin      = margin_q;
  assign confident   = confident_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_logit_argmax_classifier.sv
// Scoreboard bench for logit_argmax_classifier: stimulus pushes expected results,
// a negedge monitor pops and checks them (including the cycle of arrival).
module tb_logit_argmax_classifier;

  localparam int unsigned NC = 3;
  localparam int unsigned DW = 48;
  localparam int unsigned MW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC*DW-1:0] logits = '0;
  logic            logits_valid = 1'b0;
  logic            busy, class_valid, confident, overrun;
  logic [1:0]      class_id;
  logic [MW-1:0]   margin;

  logit_argmax_classifier #(
    .N_CLASSES (NC),
    .DATA_W    (DW),
    .MARGIN_W  (MW),
    .MARGIN_MIN(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .logits      (logits),
    .logits_valid(logits_valid),
    .busy        (busy),
    .class_valid (class_valid),
    .class_id    (class_id),
    .margin      (margin),
    .confident   (confident),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  id;
    logic [15:0] m;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (class_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_class_valid: cycle %0d id=%0d margin=%0d conf=%0d expected no result",
                 cyc, class_id, margin, confident);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.cyc || class_id !== e.id || margin !== e.m || confident !== e.c) begin
          bad++;
          $display("FAIL result: got cycle=%0d id=%0d margin=%0d conf=%0d expected cycle=%0d id=%0d margin=%0d conf=%0d",
                   cyc, class_id, margin, confident, e.cyc, e.id, e.m, e.c);
        end
      end
    end
  end

  function automatic logic [NC*DW-1:0] pack(input logic signed [DW-1:0] a, b, c);
    return {c, b, a};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Capture in the next cycle; returns #1 into the cycle after the capture edge.
  task automatic send(input logic signed [DW-1:0] a, b, c,
                      input logic [1:0] id, input logic [15:0] m, input logic cf);
    exp_t e;
    @(posedge clk); #1;
    logits       = pack(a, b, c);
    logits_valid = 1'b1;
    e.cyc = cyc + NC; e.id = id; e.m = m; e.c = cf;
    sb.push_back(e);
    @(posedge clk); #1;
    logits_valid = 1'b0;
    logits       = {$urandom, $urandom, $urandom, $urandom, $urandom};
    check("busy_in_scan", 64'(busy), 64'd1);
  endtask

  initial begin
    idle(3); #1;
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_class_valid", 64'(class_valid), 64'd0);
    check("rst_class_id", 64'(class_id), 64'd0);
    check("rst_margin", 64'(margin), 64'd0);
    check("rst_confident", 64'(confident), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    send(100, -5, 40, 2'd0, 16'd60, 1'b1);           idle(4);
    send(7, 7, -3, 2'd0, 16'd0, 1'b0);               idle(4);
    send(-900, -20, -300, 2'd1, 16'd280, 1'b1);      idle(4);
    send(48'sh010000000000, -48'sh010000000000, 0, 2'd0, 16'hFFFF, 1'b1); idle(4);
    send(5, 3, 22, 2'd2, 16'd17, 1'b1);              idle(4);

    // back-to-back: second capture on the edge that ends the first result cycle
    send(1, 2, 3, 2'd2, 16'd1, 1'b0);
    @(posedge clk);
    send(-1, -1, -4, 2'd0, 16'd0, 1'b0);
    idle(4); #1;
    check("b2b_no_overrun", 64'(overrun), 64'd0);

    // capture request while scanning is dropped and flags overrun
    send(1, 50, 2, 2'd1, 16'd48, 1'b1);
    logits       = pack(99, 0, 0);
    logits_valid = 1'b1;
    @(posedge clk); #1;
    logits_valid = 1'b0;
    idle(4); #1;
    check("overrun_set", 64'(overrun), 64'd1);
    send(100, -5, 40, 2'd0, 16'd60, 1'b1); idle(4); #1;
    check("overrun_sticky", 64'(overrun), 64'd1);

    // reset mid-scan: no result, everything cleared
    @(posedge clk); #1;
    logits       = pack(3, 80, 1);
    logits_valid = 1'b1;
    @(posedge clk); #1;
    logits_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_class_id", 64'(class_id), 64'd0);
    check("midrst_margin", 64'(margin), 64'd0);
    check("midrst_confident", 64'(confident), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    idle(5);
    send(0, 0, 9, 2'd2, 16'd9, 1'b0); idle(4);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
